// File: rtl/uart_rx.sv
// 8N1 UART receiver with a ready/valid byte output and frame-error / overrun pulses.
// The line is double-flopped, start-bit centred at half a bit, then sampled once per bit.
module uart_rx #(
  parameter int CLK_HZ = 48_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          rx_meta;
  logic          rx_s;
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_cnt_next;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          done;
  logic          done_next;
  logic          bad;
  logic          bad_next;
  logic          expired;

  // Synchronizer, FSM state and receive datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      done     <= 1'b0;
      bad      <= 1'b0;
    end else begin
      rx_meta  <= i_rx;
      rx_s     <= rx_meta;
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      done     <= done_next;
      bad      <= bad_next;
    end
  end

  assign expired = (baud_cnt == '0);

  // Next-state logic: each timed state counts down to zero, then samples rx_s.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    done_next     = 1'b0;
    bad_next      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_next    = S_START;
          bit_cnt_next  = 3'd0;
          baud_cnt_next = HALF_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_START: begin
        if (!expired) begin
          baud_cnt_next = baud_cnt - CW'(1);
        end else if (rx_s) begin
          state_next = S_IDLE;
        end else begin
          state_next    = S_DATA;
          baud_cnt_next = FULL_LOAD;
        end
      end
      S_DATA: begin
        if (!expired) begin
          baud_cnt_next = baud_cnt - CW'(1);
        end else begin
          shift_next[bit_cnt] = rx_s;
          baud_cnt_next       = FULL_LOAD;
          bit_cnt_next        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = S_STOP;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_STOP: begin
        if (!expired) begin
          baud_cnt_next = baud_cnt - CW'(1);
        end else if (rx_s) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = S_BREAK;
          bad_next   = 1'b1;
        end
      end
      S_BREAK: begin
        // A held-low line must return high before another start is accepted.
        if (rx_s) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_BREAK;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output handshake stage: delivers, drops (overrun) or clears the held byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= bad;
      o_overrun   <= 1'b0;
      if (done) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx at 10 clocks/bit: frames are scheduled as events in a
// queue and a handshake model predicts o_valid/o_data/o_frame_err/o_overrun every cycle.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 10;
  // Outputs change on the edge 99 cycles after the edge the start bit was driven from.
  localparam int LAT = 99;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         due;
    bit         bad;
    logic [7:0] data;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  ev_t        pend[$];
  ev_t        ev;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       accept;
  bit         ready_rand = 1'b0;
  bit         ready_val = 1'b0;
  int         n_rise = 0;
  int         n_ovr = 0;
  int         n_ferr = 0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: frame outcome events plus the ready/valid handshake rules.
  always @(posedge i_clk) begin
    cyc++;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (i_rst) begin
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      pend.delete();
    end else begin
      accept = exp_valid && i_ready;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ev = pend.pop_front();
        if (ev.bad) begin
          exp_ferr = 1'b1;
          if (accept) exp_valid = 1'b0;
        end else if (!exp_valid || accept) begin
          exp_data  = ev.data;
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (accept) begin
        exp_valid = 1'b0;
      end
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (cyc > 0) begin
      chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
      chk("o_data", {24'd0, o_data}, {24'd0, exp_data});
      chk("o_frame_err", {31'd0, o_frame_err}, {31'd0, exp_ferr});
      chk("o_overrun", {31'd0, o_overrun}, {31'd0, exp_ovr});
      if (o_valid === 1'b1 && prev_valid !== 1'b1) n_rise++;
      if (o_overrun === 1'b1) n_ovr++;
      if (o_frame_err === 1'b1) n_ferr++;
      prev_valid = o_valid;
    end
  end

  // Ready driver, 2 time units after each edge so the main sequence can set ready_val at +1.
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      i_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    pend.push_back('{cyc + LAT, !stop_ok, b});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  int         base_rise;
  int         base_ovr;
  int         base_ferr;
  int         gap;
  int         k;
  bit         bad_stop;
  logic [7:0] rb;

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(5);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_data", {24'd0, o_data}, 32'h00);

    // Single byte, consumer always ready: one-cycle valid.
    ready_val = 1'b1;
    idle(2);
    send_frame(8'hA5, 1'b1);
    idle(5);
    chk("a5_data", {24'd0, o_data}, 32'hA5);
    chk("a5_valid_pulses", n_rise, 1);
    chk("a5_no_errors", n_ovr + n_ferr, 0);

    // Back-to-back frames with no consumer: second byte overruns.
    ready_val = 1'b0;
    idle(4);
    base_ovr = n_ovr;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(5);
    chk("b2b_data_held", {24'd0, o_data}, 32'h3C);
    chk("b2b_valid_held", {31'd0, o_valid}, 32'd1);
    chk("b2b_overrun_pulses", n_ovr - base_ovr, 1);
    ready_val = 1'b1;
    idle(3);
    ready_val = 1'b0;

    // Held valid for 100 cycles, then exactly one ready cycle.
    send_frame(8'h5A, 1'b1);
    idle(100);
    chk("hold_valid", {31'd0, o_valid}, 32'd1);
    ready_val = 1'b1;
    @(posedge i_clk);
    #1;
    ready_val = 1'b0;
    chk("hold_valid_cleared", {31'd0, o_valid}, 32'd0);
    chk("hold_data_kept", {24'd0, o_data}, 32'h5A);

    // Low stop bit, line held low, then released: frame error and BREAK.
    ready_val = 1'b1;
    idle(5);
    base_ferr = n_ferr;
    base_rise = n_rise;
    send_frame(8'h00, 1'b0);
    i_rx = 1'b0;
    repeat (30) @(posedge i_clk);
    #1;
    chk("break_busy", {31'd0, o_busy}, 32'd1);
    idle(5);
    chk("break_exit_idle", {31'd0, o_busy}, 32'd0);
    chk("ferr_pulses", n_ferr - base_ferr, 1);
    chk("ferr_no_valid", n_rise - base_rise, 0);
    send_frame(8'h55, 1'b1);
    idle(5);
    chk("after_break_data", {24'd0, o_data}, 32'h55);

    // Four-cycle glitch on the idle line.
    base_rise = n_rise;
    i_rx = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_rx = 1'b1;
    chk("glitch_busy_seen", {31'd0, o_busy}, 32'd1);
    k = 0;
    while (o_busy === 1'b1 && k < 8) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    chk("glitch_busy_low", {31'd0, o_busy}, 32'd0);
    idle(100);
    chk("glitch_no_valid", n_rise - base_rise, 0);

    // Reset during data bit 4 of 8'hFF, then a clean 8'h81.
    pend.push_back('{cyc + LAT, 1'b0, 8'hFF});
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (5) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_mid_data", {24'd0, o_data}, 32'h00);
    idle(100);
    send_frame(8'h81, 1'b1);
    idle(5);
    chk("after_rst_data", {24'd0, o_data}, 32'h81);

    // Randomized traffic with random consumer readiness.
    ready_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 25));
      bad_stop = ($urandom_range(0, 7) == 0);
      rb = 8'($urandom);
      if (gap > 0) idle(gap);
      send_frame(rb, !bad_stop);
      if (bad_stop) idle(15);
    end
    idle(120);
    chk("all_events_consumed", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
